bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Master-side bus interface sitting directly upstream of the arbiter; one instance per master (m1, m2).
- Accepts a single read/write command from local master logic and drives `request`/`slave_sel` to the arbiter.
- Once granted, serialises the transaction (RW bit, address, write data) onto the 1-bit bus, collects read data or the write acknowledge, then pulses `trans_done` so the arbiter releases the bus.

Parameters:
- ADDR_W, 12: full address width; top 2 bits = slave select, remaining ADDR_W-2 bits = in-slave address (serialised).
- DATA_W, 8: data word width.
- TIMEOUT, 255: cycles to wait for slave response before abort (used only with the macro).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- rw  in  1  1 = write, 0 = read; captured with start.
- addr  in  ADDR_W  target address; captured with start.
- wdata  in  DATA_W  write data; captured with start.
- rdata  out  DATA_W  read data; held until next read completes.
- rdata_valid  out  1  one-cycle pulse on read completion.
- busy  out  1  high from cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse, transaction finished (ok or error).
- err  out  1  valid with done; 1 = aborted.
- request  out  1  to arbiter m*_request.
- slave_sel  out  2  to arbiter m*_slave_sel = captured addr[ADDR_W-1:ADDR_W-2].
- grant  in  1  from arbiter m*_grant.
- trans_done  out  1  to arbiter; one-cycle pulse in DONE.
- bus_dout  out  1  serial data to slave, LSB first.
- bus_dvalid  out  1  qualifies bus_dout.
- bus_din  in  1  serial read data from slave, LSB first.
- bus_din_valid  in  1  qualifies bus_din.
- slave_ready  in  1  write acknowledge from slave.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; command registers, bit counter and shift registers cleared.
- rst asserted mid-transaction aborts silently: no done, no trans_done.
- States: IDLE, REQ, SEND_RW, SEND_ADDR, SEND_DATA, WAIT_ACK, RECV_DATA, DONE.
- IDLE:
  - start=1 captures rw/addr/wdata, next state REQ.
  - start in any other state is ignored and has no effect.
- REQ:
  - request=1, slave_sel driven; request stays high through DONE.
  - On grant=1 go to SEND_RW next cycle; waits indefinitely otherwise.
- SEND_RW: bus_dvalid=1, bus_dout=rw, one cycle.
- SEND_ADDR: ADDR_W-2 cycles, address bits LSB first. Then SEND_DATA if write, RECV_DATA if read.
- SEND_DATA: DATA_W cycles, wdata LSB first, then WAIT_ACK. bus_dvalid=0 outside SEND_* states.
- WAIT_ACK: slave_ready=1 goes to DONE. slave_ready asserted before WAIT_ACK is ignored.
- RECV_DATA:
  - Each cycle with bus_din_valid=1 shifts in one bit (LSB first); cycles without it do not advance the counter.
  - After DATA_W valid bits, rdata is updated, then DONE.
- DONE, one cycle:
  - done=1 and trans_done=1.
  - rdata_valid=1 only for a successful read.
  - request=0 from the next cycle; return to IDLE, busy=0 next cycle.
- Grant lost (grant=0 in any state after REQ): abort to DONE with err=1; trans_done still pulses.
- Counter is clog2(max(ADDR_W-2, DATA_W)) bits and resets to 0 at each state entry.
- Minimum write latency, start to done: 1 (REQ) + 1 + (ADDR_W-2) + DATA_W + 1 (ack) + 1 cycles, assuming grant is present in REQ's first cycle and slave_ready in WAIT_ACK's first cycle.

Optional Feature:
- BUS_MASTER_TIMEOUT_EN defined:
  - A wait counter runs in REQ, WAIT_ACK and RECV_DATA, resetting on state entry and on each bus_din_valid.
  - Reaching TIMEOUT cycles goes to DONE with err=1.
  - In REQ, trans_done is not pulsed because the bus was never granted.
- Not defined: no counter; those states wait forever; err is set only on grant loss.

Decomposition:
- Shared package bus_pkg: state encoding enum, RW_READ/RW_WRITE constants, SLAVE_SEL_W=2, default ADDR_W/DATA_W.
- One sub-module, bus_piso_sipo: a shift register with load, shift-out, shift-in and bit counter, reused for the address, write-data and read-data phases.

Test Plan:
- Write: start, rw=1, addr=12'h8A5, wdata=8'h3C; grant after 2 cycles; slave_ready 3 cycles into WAIT_ACK -> slave_sel=2'b10, bus stream 1, then 0xA5 bits LSB-first, then 0x3C LSB-first; done and trans_done pulse once; err=0.
- Read: rw=0, addr=12'h401; slave returns 0xC3 with one idle cycle between bits -> rdata=8'hC3, rdata_valid 1 cycle, err=0.
- Second start asserted while busy -> ignored; exactly one done pulse.
- Grant dropped during SEND_DATA bit 3 -> next cycle done=1, err=1, trans_done=1, bus_dvalid=0.
- rst pulsed in RECV_DATA -> all outputs 0 immediately; no done; a new start after reset completes normally.
- With BUS_MASTER_TIMEOUT_EN and TIMEOUT=16, grant never given -> done=1, err=1 exactly 16 cycles after REQ entry; trans_done stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus master port: FSM state encoding,
// RW bit values and default widths.
package bus_pkg;

  localparam int SLAVE_SEL_W = 2;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND_RW,
    ST_SEND_ADDR,
    ST_SEND_DATA,
    ST_WAIT_ACK,
    ST_RECV_DATA,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_piso_sipo.sv
// Shared serial shift register with bit counter: parallel load then shift out
// LSB first, or shift in LSB first with the newest bit entering at the MSB.
module bus_piso_sipo #(
  parameter int W     = 10,
  parameter int OUT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_load_data,
  input  logic             i_shift_out,
  input  logic             i_shift_in,
  input  logic             i_din,
  input  logic             i_cnt_clr,
  output logic             o_dout,
  output logic [OUT_W-1:0] o_word,
  output logic [CNT_W-1:0] o_cnt
);

  logic [W-1:0]     r_sr;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_load) begin
        r_sr <= i_load_data;
      end else if (i_shift_out) begin
        r_sr <= {1'b0, r_sr[W-1:1]};
      end else if (i_shift_in) begin
        r_sr <= {i_din, r_sr[W-1:1]};
      end

      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (i_shift_out || i_shift_in) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_dout = r_sr[0];
  // Word as it will stand after the current shift-in, so the final bit can be
  // captured on the same edge it arrives.
  assign o_word = {i_din, r_sr[W-1 -: OUT_W-1]};
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: request/grant handshake, RW/address/data
// serialisation and response collection. Optional wait timeout: BUS_MASTER_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_rw,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]      i_wdata,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_rdata_valid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_request,
  output logic [SLAVE_SEL_W-1:0] o_slave_sel,
  input  logic                   i_grant,
  output logic                   o_trans_done,
  output logic                   o_bus_dout,
  output logic                   o_bus_dvalid,
  input  logic                   i_bus_din,
  input  logic                   i_bus_din_valid,
  input  logic                   i_slave_ready
);

  localparam int AW    = ADDR_W - SLAVE_SEL_W;
  localparam int SR_W  = max_int(AW, DATA_W);
  localparam int CNT_W = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AW - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_no_td;

  logic              w_capture;
  logic              w_set_err;
  logic              w_set_no_td;
  logic              w_rdata_load;
  logic              w_load;
  logic [SR_W-1:0]   w_load_data;
  logic              w_shift_out;
  logic              w_shift_in;
  logic              w_cnt_clr;
  logic              w_sr_dout;
  logic [DATA_W-1:0] w_sr_word;
  logic [CNT_W-1:0]  w_cnt;

  // Counters restart on every state change.
  assign w_cnt_clr = (w_state_next != r_state);

  bus_piso_sipo #(
    .W     (SR_W),
    .OUT_W (DATA_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_shift_out (w_shift_out),
    .i_shift_in  (w_shift_in),
    .i_din       (i_bus_din),
    .i_cnt_clr   (w_cnt_clr),
    .o_dout      (w_sr_dout),
    .o_word      (w_sr_word),
    .o_cnt       (w_cnt)
  );

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait;
  logic          w_wait_en;
  logic          w_timeout;

  assign w_wait_en = (r_state == ST_REQ) || (r_state == ST_WAIT_ACK) ||
                     (r_state == ST_RECV_DATA);
  assign w_timeout = (r_wait == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait <= '0;
    end else if (w_cnt_clr || i_bus_din_valid) begin
      r_wait <= '0;
    end else if (w_wait_en) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_no_td <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_rw    <= i_rw;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_err   <= 1'b0;
        r_no_td <= 1'b0;
      end
      if (w_set_err)    r_err   <= 1'b1;
      if (w_set_no_td)  r_no_td <= 1'b1;
      if (w_rdata_load) r_rdata <= w_sr_word;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_set_err    = 1'b0;
    w_set_no_td  = 1'b0;
    w_rdata_load = 1'b0;
    w_load       = 1'b0;
    w_load_data  = SR_W'(r_addr[AW-1:0]);
    w_shift_out  = 1'b0;
    w_shift_in   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_capture    = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_grant) begin
          w_state_next = ST_SEND_RW;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
          w_set_no_td  = 1'b1;
        end
`endif
      end
      ST_SEND_RW: begin
        w_load = 1'b1;
        if (!i_grant) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end else begin
          w_state_next = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        w_shift_out = 1'b1;
        if (!i_grant) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end else if (w_cnt == ADDR_LAST) begin
          if (r_rw == RW_WRITE) begin
            w_load       = 1'b1;
            w_load_data  = SR_W'(r_wdata);
            w_state_next = ST_SEND_DATA;
          end else begin
            w_state_next = ST_RECV_DATA;
          end
        end
      end
      ST_SEND_DATA: begin
        w_shift_out = 1'b1;
        if (!i_grant) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end else if (w_cnt == DATA_LAST) begin
          w_state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!i_grant) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end else if (i_slave_ready) begin
          w_state_next = ST_DONE;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end
`endif
      end
      ST_RECV_DATA: begin
        w_shift_in = i_bus_din_valid;
        if (!i_grant) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end else if (i_bus_din_valid && (w_cnt == DATA_LAST)) begin
          w_rdata_load = 1'b1;
          w_state_next = ST_DONE;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_next = ST_DONE;
          w_set_err    = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_request     = (r_state != ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_slave_sel   = o_request ? r_addr[ADDR_W-1 -: SLAVE_SEL_W] : '0;
  assign o_done        = (r_state == ST_DONE);
  assign o_err         = o_done && r_err;
  assign o_trans_done  = o_done && !r_no_td;
  assign o_rdata_valid = o_done && !r_err && (r_rw == RW_READ);
  assign o_rdata       = r_rdata;
  assign o_bus_dvalid  = (r_state == ST_SEND_RW) || (r_state == ST_SEND_ADDR) ||
                         (r_state == ST_SEND_DATA);
  assign o_bus_dout    = (r_state == ST_SEND_RW) ? r_rw : (o_bus_dvalid && w_sr_dout);

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: write, read, ignored start, grant loss,
// mid-transaction reset, and the no-grant case (timeout when BUS_MASTER_TIMEOUT_EN).
module tb_bus_master_port;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_rw, i_grant, i_bus_din, i_bus_din_valid, i_slave_ready;
  logic [11:0] i_addr;
  logic [7:0]  i_wdata;
  logic [7:0]  o_rdata;
  logic        o_rdata_valid, o_busy, o_done, o_err, o_request, o_trans_done;
  logic [1:0]  o_slave_sel;
  logic        o_bus_dout, o_bus_dvalid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_W  (12),
    .DATA_W  (8),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (i_start),
    .i_rw            (i_rw),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .o_rdata         (o_rdata),
    .o_rdata_valid   (o_rdata_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_request       (o_request),
    .o_slave_sel     (o_slave_sel),
    .i_grant         (i_grant),
    .o_trans_done    (o_trans_done),
    .o_bus_dout      (o_bus_dout),
    .o_bus_dvalid    (o_bus_dvalid),
    .i_bus_din       (i_bus_din),
    .i_bus_din_valid (i_bus_din_valid),
    .i_slave_ready   (i_slave_ready)
  );

  function automatic logic [17:0] outs();
    return {o_request, o_busy, o_done, o_err, o_trans_done, o_rdata_valid,
            o_bus_dvalid, o_bus_dout, o_slave_sel, o_rdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the sample point of the first REQ cycle (k=1).
  task automatic issue(input logic rw, input logic [11:0] a, input logic [7:0] d);
    i_rw    = rw;
    i_addr  = a;
    i_wdata = d;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (outs() !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h expected 0", outs());
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (outs() !== 18'h0) begin
      bad++;
      $display("FAIL reset_release_idle: got %0h expected 0", outs());
    end
    $display("reset: outputs=%0h", outs());
  endtask

  task automatic test_write();
    logic [18:0] stream;
    logic [18:0] exp_stream;
    int nbits, ndone, ntd, done_k;
    logic err_at, rv_at;
    stream = '0; exp_stream = {8'h3C, 10'h0A5, 1'b1};
    nbits = 0; ndone = 0; ntd = 0; done_k = -1; err_at = 1'bx; rv_at = 1'bx;
    i_grant = 1'b0; i_slave_ready = 1'b0;
    issue(1'b1, 12'h8A5, 8'h3C);
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        total++;
        if ({o_request, o_busy, o_slave_sel} !== 4'b1110) begin
          bad++;
          $display("FAIL write_req: got %b expected 1110", {o_request, o_busy, o_slave_sel});
        end
      end
      if (o_bus_dvalid) begin
        if (nbits < 19) stream[nbits] = o_bus_dout;
        nbits++;
      end
      if (o_done) begin
        ndone++; done_k = k; err_at = o_err; rv_at = o_rdata_valid;
      end
      if (o_trans_done) ntd++;
      if (k == 26) begin
        total++;
        if ({o_request, o_busy} !== 2'b00) begin
          bad++;
          $display("FAIL write_release: got %b expected 00", {o_request, o_busy});
        end
      end
      i_grant       = (k >= 2 && k < 25);
      i_slave_ready = (k == 5 || k == 24);
      tick();
    end
    i_slave_ready = 1'b0;
    total++;
    if (nbits !== 19) begin
      bad++;
      $display("FAIL write_bitcount: got %0d expected 19", nbits);
    end
    total++;
    if (stream !== exp_stream) begin
      bad++;
      $display("FAIL write_stream: got %h expected %h", stream, exp_stream);
    end
    total++;
    if (done_k !== 25) begin
      bad++;
      $display("FAIL write_done_cycle: got %0d expected 25", done_k);
    end
    total++;
    if ({ndone, ntd} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL write_pulses: got done=%0d trans_done=%0d expected 1 1", ndone, ntd);
    end
    total++;
    if ({err_at, rv_at} !== 2'b00) begin
      bad++;
      $display("FAIL write_err: got err=%b rdata_valid=%b expected 0 0", err_at, rv_at);
    end
    $display("write addr=8a5 wdata=3c: done at cycle %0d err=%b bits=%0d", done_k, err_at, nbits);
  endtask

  // Also pulses start twice while busy; both must be ignored.
  task automatic test_read();
    logic [10:0] stream;
    logic [10:0] exp_stream;
    logic [7:0]  word;
    int nbits, ndone, nrv, done_k;
    logic err_at;
    logic [7:0] rdata_at;
    stream = '0; exp_stream = {10'h001, 1'b0}; word = 8'hC3;
    nbits = 0; ndone = 0; nrv = 0; done_k = -1; err_at = 1'bx; rdata_at = 'x;
    i_grant = 1'b1;
    issue(1'b0, 12'h401, 8'h00);
    for (int k = 1; k <= 40; k++) begin
      if (k == 1 || k == 21) begin
        total++;
        if (o_slave_sel !== 2'b01) begin
          bad++;
          $display("FAIL read_slave_sel_k%0d: got %b expected 01", k, o_slave_sel);
        end
      end
      if (o_bus_dvalid) begin
        if (nbits < 11) stream[nbits] = o_bus_dout;
        nbits++;
      end
      if (o_done) begin
        ndone++; done_k = k; err_at = o_err; rdata_at = o_rdata;
      end
      if (o_rdata_valid) nrv++;
      if (k == 32) begin
        total++;
        if (o_busy !== 1'b0) begin
          bad++;
          $display("FAIL read_idle_after: got busy=%b expected 0", o_busy);
        end
      end
      i_start = (k == 5 || k == 20);
      if (i_start) begin
        i_rw = 1'b1; i_addr = 12'hFFF;
      end
      i_bus_din_valid = (k >= 13 && k <= 27 && ((k - 13) % 2 == 0));
      i_bus_din       = i_bus_din_valid ? word[(k - 13) / 2] : 1'b0;
      i_grant         = (k < 28);
      tick();
    end
    i_start = 1'b0;
    total++;
    if (stream !== exp_stream || nbits !== 11) begin
      bad++;
      $display("FAIL read_stream: got %h/%0d expected %h/11", stream, nbits, exp_stream);
    end
    total++;
    if (done_k !== 28) begin
      bad++;
      $display("FAIL read_done_cycle: got %0d expected 28", done_k);
    end
    total++;
    if ({ndone, nrv} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL read_pulses: got done=%0d rdata_valid=%0d expected 1 1", ndone, nrv);
    end
    total++;
    if ({err_at, rdata_at} !== {1'b0, 8'hC3}) begin
      bad++;
      $display("FAIL read_data: got err=%b rdata=%h expected 0 c3", err_at, rdata_at);
    end
    total++;
    if (o_rdata !== 8'hC3) begin
      bad++;
      $display("FAIL read_data_held: got %h expected c3", o_rdata);
    end
    $display("read addr=401: rdata=%h done at cycle %0d err=%b", rdata_at, done_k, err_at);
  endtask

  task automatic test_grant_loss();
    int ndone;
    ndone = 0;
    i_grant = 1'b1;
    issue(1'b1, 12'h3FF, 8'hA7);
    for (int k = 1; k <= 25; k++) begin
      if (o_done) ndone++;
      if (k == 16) begin
        total++;
        if ({o_bus_dvalid, o_bus_dout} !== 2'b10) begin
          bad++;
          $display("FAIL gl_data_bit3: got %b expected 10", {o_bus_dvalid, o_bus_dout});
        end
      end
      if (k == 17) begin
        total++;
        if ({o_done, o_err, o_trans_done, o_bus_dvalid, o_rdata_valid} !== 5'b11100) begin
          bad++;
          $display("FAIL gl_abort: got %b expected 11100",
                   {o_done, o_err, o_trans_done, o_bus_dvalid, o_rdata_valid});
        end
      end
      if (k == 18) begin
        total++;
        if ({o_request, o_busy} !== 2'b00) begin
          bad++;
          $display("FAIL gl_release: got %b expected 00", {o_request, o_busy});
        end
      end
      if (k == 16) i_grant = 1'b0;
      tick();
    end
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("FAIL gl_done_count: got %0d expected 1", ndone);
    end
    $display("write addr=3ff wdata=a7 grant dropped: done count=%0d", ndone);
  endtask

  task automatic test_reset_mid();
    int ndone, done_k;
    logic [7:0] word;
    logic [7:0] rdata_at;
    ndone = 0; done_k = -1; word = 8'h5A; rdata_at = 'x;
    i_grant = 1'b1;
    issue(1'b0, 12'h2AB, 8'h00);
    for (int k = 1; k < 15; k++) begin
      i_bus_din_valid = (k >= 13);
      i_bus_din       = 1'b1;
      tick();
    end
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL rm_busy_before: got %b expected 1", o_busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 18'h0) begin
      bad++;
      $display("FAIL rm_async_clear: got %0h expected 0", outs());
    end
    tick();
    rst = 1'b0;
    i_bus_din_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_done || o_trans_done) ndone++;
      tick();
    end
    total++;
    if ({ndone, o_busy} !== {32'd0, 1'b0}) begin
      bad++;
      $display("FAIL rm_silent: got done=%0d busy=%b expected 0 0", ndone, o_busy);
    end
    $display("read addr=2ab reset mid-transfer: done count=%0d", ndone);
    issue(1'b0, 12'hC12, 8'h00);
    for (int k = 1; k <= 30; k++) begin
      if (k == 1) begin
        total++;
        if (o_slave_sel !== 2'b11) begin
          bad++;
          $display("FAIL rm_new_slave_sel: got %b expected 11", o_slave_sel);
        end
      end
      if (o_done) begin
        ndone++; done_k = k; rdata_at = o_rdata;
      end
      i_bus_din_valid = (k >= 13 && k <= 20);
      i_bus_din       = i_bus_din_valid ? word[k - 13] : 1'b0;
      tick();
    end
    total++;
    if ({ndone, done_k, rdata_at} !== {32'd1, 32'd21, 8'h5A}) begin
      bad++;
      $display("FAIL rm_new_read: got done=%0d cycle=%0d rdata=%h expected 1 21 5a",
               ndone, done_k, rdata_at);
    end
    $display("read addr=c12 after reset: rdata=%h done at cycle %0d", rdata_at, done_k);
  endtask

  task automatic test_no_grant();
    int ndone, ntd, done_k;
    logic err_at;
    ndone = 0; ntd = 0; done_k = -1; err_at = 1'bx;
    i_grant = 1'b0;
    issue(1'b1, 12'h123, 8'h55);
    for (int k = 1; k <= 40; k++) begin
      if (o_done) begin
        ndone++; done_k = k; err_at = o_err;
      end
      if (o_trans_done) ntd++;
      tick();
    end
`ifdef BUS_MASTER_TIMEOUT_EN
    total++;
    if ({ndone, done_k, err_at, ntd} !== {32'd1, 32'd17, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL ng_timeout: got done=%0d cycle=%0d err=%b trans_done=%0d expected 1 17 1 0",
               ndone, done_k, err_at, ntd);
    end
`else
    total++;
    if ({ndone, o_request, o_busy} !== {32'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ng_wait_forever: got done=%0d request=%b busy=%b expected 0 1 1",
               ndone, o_request, o_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (o_request !== 1'b0) begin
      bad++;
      $display("FAIL ng_reset_release: got %b expected 0", o_request);
    end
`endif
    $display("write addr=123 no grant: done count=%0d cycle=%0d err=%b", ndone, done_k, err_at);
  endtask

  initial begin
    i_start = 1'b0; i_rw = 1'b0; i_addr = '0; i_wdata = '0; i_grant = 1'b0;
    i_bus_din = 1'b0; i_bus_din_valid = 1'b0; i_slave_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_grant_loss();
    test_reset_mid();
    test_no_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
